// File: rtl/id_ex_if.sv
// ---------------------------------------------------------------------------
// id_ex_if -- bundle of the ID-side inputs and EX-side outputs of the ID/EX
// pipeline register.
//
//   master : the ID/control side. It drives id_*, flush and ex_stall, and it
//            observes ex_*, id_stall and bubble_cnt.
//   slave  : the id_ex_stage register itself (the reverse directions).
//
// Parameters
//   CTRL_W : width of the packed control bundle.
//            bit 0 = reg_write, bit 1 = mem_read, bit 2 = mem_write.
//   CNT_W  : width of the debug bubble counter.
// ---------------------------------------------------------------------------
interface id_ex_if #(
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
);
  // ID side
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [31:0]       id_rs_data;
  logic [31:0]       id_rt_data;
  logic [31:0]       id_imme_32;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic              id_uses_rt;
  logic [CTRL_W-1:0] id_ctrl;

  // Pipeline control
  logic              flush;
  logic              ex_stall;

  // EX side
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_rs_data;
  logic [31:0]       ex_rt_data;
  logic [31:0]       ex_imme_32;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;

  // Hazard / debug
  logic              id_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_pc, id_rs_data, id_rt_data, id_imme_32,
           id_rs, id_rt, id_rd, id_uses_rt, id_ctrl, flush, ex_stall,
    input  ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imme_32,
           ex_rs, ex_rt, ex_rd, ex_ctrl, id_stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs_data, id_rt_data, id_imme_32,
           id_rs, id_rt, id_rd, id_uses_rt, id_ctrl, flush, ex_stall,
    output ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imme_32,
           ex_rs, ex_rt, ex_rd, ex_ctrl, id_stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register for the five-stage CPU.
//
// This block captures the decoded ID instruction and presents it to EX one
// cycle later. The captured fields are the operands, the sign-extended
// immediate, the register specifiers and the control bundle. The block also
// detects load-use hazards, inserts bubbles on a hazard or a branch flush,
// and keeps a saturating count of the inserted bubbles for debug.
//
// Ports
//   clk    : pipeline clock. All state updates on the rising edge.
//   rst_n  : asynchronous active-low reset. It clears every ex_* field and
//            bubble_cnt.
//   bus    : id_ex_if.slave
//            id_*      : decoded instruction from ID
//            flush     : taken branch/jump in EX. Kill the ID instruction.
//            ex_stall  : EX/MEM cannot accept. Hold everything.
//            ex_*      : registered copies for EX
//            id_stall  : combinational freeze request for PC and IF/ID
//            bubble_cnt: saturating number of flush/load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  id_ex_if.slave bus
);

  localparam int CTRL_MEM_READ = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [31:0]       imme_32;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } ex_reg_t;

  ex_reg_t          ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             rs_match, rt_match;

  // Load-use hazard: the instruction in EX is a load with a real destination,
  // and the ID instruction reads that register. A destination of r0 never
  // causes a hazard, because r0 is hard-wired to zero.
  assign rs_match = (ex_q.rt == bus.id_rs);
  assign rt_match = bus.id_uses_rt && (ex_q.rt == bus.id_rt);
  assign load_use = ex_q.valid && ex_q.ctrl[CTRL_MEM_READ] &&
                    (ex_q.rt != 5'd0) && bus.id_valid &&
                    (rs_match || rt_match);

  assign bus.id_stall = load_use || bus.ex_stall;

  always_comb begin
    // NOTE: every output of this block gets a default first. Without the
    // defaults, a path that does not assign a signal would infer a latch.
    ex_d  = ex_q;
    cnt_d = cnt_q;

    if (!bus.ex_stall) begin
      if (bus.flush || load_use) begin
        // Bubble. A flush and a load-use in the same cycle still make only
        // one bubble, so the counter advances by one.
        ex_d = '0;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        ex_d.valid   = bus.id_valid;
        ex_d.pc      = bus.id_pc;
        ex_d.rs_data = bus.id_rs_data;
        ex_d.rt_data = bus.id_rt_data;
        ex_d.imme_32 = bus.id_imme_32;
        ex_d.rs      = bus.id_rs;
        ex_d.rt      = bus.id_rt;
        ex_d.rd      = bus.id_rd;
        // An empty ID slot must never carry write-enables into EX.
        ex_d.ctrl    = bus.id_valid ? bus.id_ctrl : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments. With them, every
    // register samples the values from before the edge, whatever order the
    // always blocks run in.
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_pc      = ex_q.pc;
  assign bus.ex_rs_data = ex_q.rs_data;
  assign bus.ex_rt_data = ex_q.rt_data;
  assign bus.ex_imme_32 = ex_q.imme_32;
  assign bus.ex_rs      = ex_q.rs;
  assign bus.ex_rt      = ex_q.rt;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_ctrl    = ex_q.ctrl;
  assign bus.bubble_cnt = cnt_q;

endmodule
